// File: rtl/mem_sram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_sram_ctrl_pkg
// Description : Shared encodings for the MEM-stage data-memory controller:
//               memory micro-ops, DRESEL bus width, address-error exception
//               codes, FSM states and micro-op classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_sram_ctrl_pkg;

    // Memory micro-op encodings carried down the pipeline from decode
    localparam logic [3:0] c_MEMOP_NONE = 4'd0;
    localparam logic [3:0] c_MEMOP_LB   = 4'd1;
    localparam logic [3:0] c_MEMOP_LBU  = 4'd2;
    localparam logic [3:0] c_MEMOP_LH   = 4'd3;
    localparam logic [3:0] c_MEMOP_LHU  = 4'd4;
    localparam logic [3:0] c_MEMOP_LW   = 4'd5;
    localparam logic [3:0] c_MEMOP_SB   = 4'd6;
    localparam logic [3:0] c_MEMOP_SH   = 4'd7;
    localparam logic [3:0] c_MEMOP_SW   = 4'd8;

    // DRESEL bus: [3:0] byte-lane select, [4] sign-extend
    localparam int c_DRESEL_W = 5;

    // Exception codes raised by this stage
    localparam logic [4:0] c_EXC_ADEL = 5'd4;
    localparam logic [4:0] c_EXC_ADES = 5'd5;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic memop_is_load(input logic [3:0] op);
        return (op == c_MEMOP_LB)  || (op == c_MEMOP_LBU) ||
               (op == c_MEMOP_LH)  || (op == c_MEMOP_LHU) ||
               (op == c_MEMOP_LW);
    endfunction

    function automatic logic memop_is_store(input logic [3:0] op);
        return (op == c_MEMOP_SB) || (op == c_MEMOP_SH) || (op == c_MEMOP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_sram_ctrl_lane_gen.sv
`default_nettype none
// ============================================================================
// Module      : mem_sram_ctrl_lane_gen
// Description : Combinational byte-lane generator. Maps micro-op and the low
//               address bits to store strobes, lane-replicated store data,
//               the load lane/sign-extend selector and the misalign flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sram_ctrl_lane_gen
    import mem_sram_ctrl_pkg::*;
(
    input  logic [3:0]            i_memop,
    input  logic [1:0]            i_addr_lo,
    input  logic [31:0]           i_din,
    output logic [3:0]            o_we,
    output logic [31:0]           o_wdata,
    output logic [c_DRESEL_W-1:0] o_dre,
    output logic                  o_misalign
);

    logic [3:0] w_lanes;
    logic       w_sext;
    logic       w_is_load;
    logic       w_is_store;

    assign w_is_load  = memop_is_load(i_memop);
    assign w_is_store = memop_is_store(i_memop);

    // Little-endian lane map, access-size alignment and store replication
    always_comb begin
        w_lanes    = 4'b0000;
        o_wdata    = i_din;
        o_misalign = 1'b0;
        w_sext     = (i_memop == c_MEMOP_LB) || (i_memop == c_MEMOP_LH);
        case (i_memop)
            c_MEMOP_LB, c_MEMOP_LBU, c_MEMOP_SB: begin
                w_lanes = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_din[7:0]}};
            end
            c_MEMOP_LH, c_MEMOP_LHU, c_MEMOP_SH: begin
                w_lanes    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata    = {2{i_din[15:0]}};
                o_misalign = i_addr_lo[0];
            end
            c_MEMOP_LW, c_MEMOP_SW: begin
                w_lanes    = 4'b1111;
                o_misalign = |i_addr_lo;
            end
            default: begin
                w_lanes = 4'b0000;
            end
        endcase
        o_we  = w_is_store ? w_lanes : 4'b0000;
        o_dre = w_is_load ? {w_sext, w_lanes} : {c_DRESEL_W{1'b0}};
    end

endmodule
`default_nettype wire

// File: rtl/mem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_sram_ctrl
// Description : MEM-stage data-memory access controller. Issues load/store
//               requests on a req/ack SRAM bus, stalls the pipeline while an
//               access is outstanding, raises address-error exceptions and
//               produces the values registered by memwb_reg.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter logic [15:0] DEV_BASE = 16'hBFAF,
    parameter int          ADDR_W   = 32
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst_n,
    input  logic [3:0]            mem_memop_i,
    input  logic [ADDR_W-1:0]     mem_addr_i,
    input  logic [31:0]           mem_wd_i,
    input  logic [31:0]           mem_din_i,
    input  logic                  mem_wreg_i,
    input  logic                  flush,
    output logic [31:0]           mem_dreg,
    output logic [c_DRESEL_W-1:0] mem_dre,
    output logic                  mem_mreg,
    output logic                  mem_wreg,
    output logic                  mem_device,
    output logic                  stall_req,
    output logic                  exc_adel,
    output logic                  exc_ades,
    output logic [ADDR_W-1:0]     badvaddr,
    output logic                  data_sram_req,
    output logic [3:0]            data_sram_we,
    output logic [ADDR_W-1:0]     data_sram_addr,
    output logic [31:0]           data_sram_wdata,
    input  logic                  data_sram_ack,
    input  logic [31:0]           data_sram_rdata
);

    state_t              r_state;
    state_t              w_next_state;
    logic                r_req;
    logic [3:0]          r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_flush_pend;

    logic [3:0]          w_we;
    logic [31:0]         w_wdata;
    logic                w_misalign;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_is_mem;
    logic                w_issue;

    mem_sram_ctrl_lane_gen u_lane_gen (
        .i_memop    (mem_memop_i),
        .i_addr_lo  (mem_addr_i[1:0]),
        .i_din      (mem_din_i),
        .o_we       (w_we),
        .o_wdata    (w_wdata),
        .o_dre      (mem_dre),
        .o_misalign (w_misalign)
    );

    assign w_is_load  = memop_is_load(mem_memop_i);
    assign w_is_store = memop_is_store(mem_memop_i);
    assign w_is_mem   = w_is_load | w_is_store;
    // A misaligned access never reaches the bus; a flush in IDLE squashes issue
    assign w_issue    = w_is_mem & ~w_misalign & ~flush;

    // State register
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bus request registers, read-data latch and pending-flush tracking
    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            r_req        <= 1'b0;
            r_we         <= 4'b0000;
            r_addr       <= '0;
            r_wdata      <= 32'h0;
            r_rdata      <= 32'h0;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_req        <= 1'b1;
                        r_addr       <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                        r_we         <= w_we;
                        r_wdata      <= w_wdata;
                        r_flush_pend <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (data_sram_ack) begin
                        r_req        <= 1'b0;
                        r_rdata      <= data_sram_rdata;
                        r_flush_pend <= 1'b0;
                    end else if (flush) begin
                        // The request is already on the bus and cannot be
                        // withdrawn; remember to drop its result instead.
                        r_flush_pend <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and stall decode
    always_comb begin
        w_next_state = r_state;
        stall_req    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                stall_req = w_issue;
                if (w_issue) begin
                    w_next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                stall_req = 1'b1;
                if (data_sram_ack) begin
                    // A flush arriving together with ack also discards the data
                    w_next_state = (r_flush_pend | flush) ? ST_IDLE : ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign data_sram_req   = r_req;
    assign data_sram_we    = r_we;
    assign data_sram_addr  = r_addr;
    assign data_sram_wdata = r_wdata;

    assign mem_dreg   = ((r_state == ST_DONE) && w_is_load) ? r_rdata : mem_wd_i;
    assign mem_mreg   = w_is_load;
    assign mem_wreg   = mem_wreg_i & ~(w_is_mem & w_misalign);
    assign mem_device = w_is_mem && (mem_addr_i[ADDR_W-1:ADDR_W-16] == DEV_BASE);
    assign exc_adel   = w_is_load & w_misalign;
    assign exc_ades   = w_is_store & w_misalign;
    assign badvaddr   = (w_is_mem & w_misalign) ? mem_addr_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_sram_ctrl
// Description : Self-checking bench for mem_sram_ctrl: directed scenarios
//               followed by random load/store/ALU traffic checked against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_sram_ctrl;
    import mem_sram_ctrl_pkg::*;

    logic        cpu_clk_50M = 1'b0;
    logic        cpu_rst_n;
    logic [3:0]  mem_memop_i;
    logic [31:0] mem_addr_i, mem_wd_i, mem_din_i;
    logic        mem_wreg_i, flush;
    logic [31:0] mem_dreg;
    logic [4:0]  mem_dre;
    logic        mem_mreg, mem_wreg, mem_device, stall_req, exc_adel, exc_ades;
    logic [31:0] badvaddr;
    logic        data_sram_req;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_ack;
    logic [31:0] data_sram_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_sram_ctrl dut (
        .cpu_clk_50M     (cpu_clk_50M),
        .cpu_rst_n       (cpu_rst_n),
        .mem_memop_i     (mem_memop_i),
        .mem_addr_i      (mem_addr_i),
        .mem_wd_i        (mem_wd_i),
        .mem_din_i       (mem_din_i),
        .mem_wreg_i      (mem_wreg_i),
        .flush           (flush),
        .mem_dreg        (mem_dreg),
        .mem_dre         (mem_dre),
        .mem_mreg        (mem_mreg),
        .mem_wreg        (mem_wreg),
        .mem_device      (mem_device),
        .stall_req       (stall_req),
        .exc_adel        (exc_adel),
        .exc_ades        (exc_ades),
        .badvaddr        (badvaddr),
        .data_sram_req   (data_sram_req),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_ack   (data_sram_ack),
        .data_sram_rdata (data_sram_rdata)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk_50M);
        #1;
    endtask

    // ---------------- reference model (access-size arithmetic) -------------
    function automatic int m_size(input logic [3:0] op);
        case (op)
            c_MEMOP_LB, c_MEMOP_LBU, c_MEMOP_SB: return 1;
            c_MEMOP_LH, c_MEMOP_LHU, c_MEMOP_SH: return 2;
            c_MEMOP_LW, c_MEMOP_SW:              return 4;
            default:                             return 0;
        endcase
    endfunction

    function automatic bit m_load(input logic [3:0] op);
        return op inside {c_MEMOP_LB, c_MEMOP_LBU, c_MEMOP_LH, c_MEMOP_LHU, c_MEMOP_LW};
    endfunction

    function automatic bit m_signed(input logic [3:0] op);
        return op inside {c_MEMOP_LB, c_MEMOP_LH};
    endfunction

    function automatic bit m_mis(input logic [3:0] op, input logic [31:0] a);
        int s = m_size(op);
        return (s > 0) && ((int'(a[1:0]) % s) != 0);
    endfunction

    function automatic logic [3:0] m_lanes(input logic [3:0] op, input logic [31:0] a);
        int s = m_size(op);
        return 4'(((1 << s) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
        case (m_size(op))
            1:       return (d & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (d & 32'h0000_FFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    // One MEM-stage transaction; entered just after a rising edge
    task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] din, input logic wreg,
                          input int waits, input logic [31:0] rdata);
        bit is_mem = m_size(op) > 0;
        bit ld     = m_load(op);
        bit mis    = m_mis(op, addr);
        bit issue  = is_mem && !mis;
        mem_memop_i   = op;
        mem_addr_i    = addr;
        mem_wd_i      = wd;
        mem_din_i     = din;
        mem_wreg_i    = wreg;
        flush         = 1'b0;
        data_sram_ack = 1'b0;
        @(negedge cpu_clk_50M);
        chk({nm, "_stall"},  32'(stall_req),  32'(issue));
        chk({nm, "_adel"},   32'(exc_adel),   32'(ld && mis));
        chk({nm, "_ades"},   32'(exc_ades),   32'(is_mem && !ld && mis));
        chk({nm, "_badva"},  badvaddr,        mis ? addr : 32'h0);
        chk({nm, "_dev"},    32'(mem_device), 32'(is_mem && addr[31:16] == 16'hBFAF));
        chk({nm, "_mreg"},   32'(mem_mreg),   32'(ld));
        chk({nm, "_wreg"},   32'(mem_wreg),   32'(wreg && !mis));
        chk({nm, "_req0"},   32'(data_sram_req), 32'h0);
        if (ld && !mis)
            chk({nm, "_dre"}, 32'(mem_dre), 32'({m_signed(op), m_lanes(op, addr)}));
        if (!ld)
            chk({nm, "_dre0"}, 32'(mem_dre), 32'h0);
        if (!is_mem)
            chk({nm, "_dreg"}, mem_dreg, wd);
        step();
        if (issue) begin
            for (int i = 0; i <= waits; i++) begin
                data_sram_ack   = (i == waits);
                data_sram_rdata = (i == waits) ? rdata : $urandom;
                @(negedge cpu_clk_50M);
                chk({nm, "_req"},   32'(data_sram_req), 32'h1);
                chk({nm, "_addr"},  data_sram_addr, {addr[31:2], 2'b00});
                chk({nm, "_we"},    32'(data_sram_we), ld ? 32'h0 : 32'(m_lanes(op, addr)));
                if (!ld)
                    chk({nm, "_wdata"}, data_sram_wdata, m_wdata(op, din));
                chk({nm, "_rstall"}, 32'(stall_req), 32'h1);
                step();
            end
            data_sram_ack = 1'b0;
            @(negedge cpu_clk_50M);
            chk({nm, "_dstall"}, 32'(stall_req), 32'h0);
            chk({nm, "_dreq"},   32'(data_sram_req), 32'h0);
            if (ld)
                chk({nm, "_ldata"}, mem_dreg, rdata);
            step();
        end
    endtask

    initial begin
        cpu_rst_n       = 1'b0;
        mem_memop_i     = c_MEMOP_NONE;
        mem_addr_i      = 32'h0;
        mem_wd_i        = 32'h1111_2222;
        mem_din_i       = 32'h0;
        mem_wreg_i      = 1'b0;
        flush           = 1'b0;
        data_sram_ack   = 1'b0;
        data_sram_rdata = 32'h0;
        step();
        step();
        @(negedge cpu_clk_50M);
        chk("rst_req",   32'(data_sram_req), 32'h0);
        chk("rst_we",    32'(data_sram_we),  32'h0);
        chk("rst_addr",  data_sram_addr,     32'h0);
        chk("rst_wdata", data_sram_wdata,    32'h0);
        chk("rst_stall", 32'(stall_req),     32'h0);
        chk("rst_dreg",  mem_dreg,           32'h1111_2222);
        step();
        cpu_rst_n = 1'b1;

        // Zero-wait LW, 3-wait SB, misaligned LH
        run_op("t1_lw", c_MEMOP_LW, 32'h0000_1004, 32'h5, 32'h0, 1'b1, 0, 32'hDEAD_BEEF);
        run_op("t2_sb", c_MEMOP_SB, 32'h0000_2002, 32'h6, 32'h0000_00AB, 1'b0, 3, 32'h0);
        run_op("t3_lh", c_MEMOP_LH, 32'h0000_3001, 32'h7, 32'h0, 1'b1, 0, 32'h0);

        // Flush in IDLE squashes issue; flush in REQ discards the result
        mem_memop_i = c_MEMOP_LW;
        mem_addr_i  = 32'h0000_5000;
        mem_wd_i    = 32'hCAFE_0004;
        mem_wreg_i  = 1'b1;
        flush       = 1'b1;
        @(negedge cpu_clk_50M);
        chk("t4_iflush_stall", 32'(stall_req), 32'h0);
        step();
        flush = 1'b0;
        @(negedge cpu_clk_50M);
        chk("t4_iflush_req", 32'(data_sram_req), 32'h0);
        chk("t4_issue_stall", 32'(stall_req), 32'h1);
        step();
        flush = 1'b1;
        @(negedge cpu_clk_50M);
        chk("t4_req1", 32'(data_sram_req), 32'h1);
        step();
        flush = 1'b0;
        @(negedge cpu_clk_50M);
        chk("t4_req2", 32'(data_sram_req), 32'h1);
        chk("t4_stall2", 32'(stall_req), 32'h1);
        step();
        data_sram_ack   = 1'b1;
        data_sram_rdata = 32'h1234_5678;
        @(negedge cpu_clk_50M);
        chk("t4_req3", 32'(data_sram_req), 32'h1);
        chk("t4_stall3", 32'(stall_req), 32'h1);
        step();
        data_sram_ack = 1'b0;
        flush         = 1'b1;
        @(negedge cpu_clk_50M);
        chk("t4_nodone_dreg", mem_dreg, 32'hCAFE_0004);
        chk("t4_post_stall", 32'(stall_req), 32'h0);
        chk("t4_post_req", 32'(data_sram_req), 32'h0);
        step();
        flush       = 1'b0;
        mem_memop_i = c_MEMOP_NONE;

        // SW to device region, reset while the request is outstanding
        mem_memop_i = c_MEMOP_SW;
        mem_addr_i  = 32'hBFAF_8000;
        mem_din_i   = 32'h0BAD_F00D;
        @(negedge cpu_clk_50M);
        chk("t5_dev", 32'(mem_device), 32'h1);
        step();
        @(negedge cpu_clk_50M);
        chk("t5_req", 32'(data_sram_req), 32'h1);
        chk("t5_we", 32'(data_sram_we), 32'hF);
        step();
        cpu_rst_n = 1'b0;
        step();
        cpu_rst_n   = 1'b1;
        mem_memop_i = c_MEMOP_NONE;
        mem_wd_i    = 32'h0000_0077;
        @(negedge cpu_clk_50M);
        chk("t5_rst_req", 32'(data_sram_req), 32'h0);
        chk("t5_rst_stall", 32'(stall_req), 32'h0);
        chk("t5_rst_dreg", mem_dreg, 32'h0000_0077);
        step();

        // LB at byte 3 immediately followed by an ALU op
        run_op("t6_lb", c_MEMOP_LB, 32'h0000_4003, 32'h0, 32'h0, 1'b1, 1, 32'h8000_0000);
        run_op("t6_addu", c_MEMOP_NONE, 32'h0000_0010, 32'h0000_0042, 32'h0, 1'b1, 0, 32'h0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  op;
            logic [31:0] a;
            op = 4'($urandom_range(0, 8));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) a[31:16] = 16'hBFAF;
            run_op("rnd", op, a, $urandom, $urandom, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_sram_ctrl.md
Name: mem_sram_ctrl

Overview:
MEM-stage data-memory access controller, placed between exmem_reg and memwb_reg.
- Turns load/store micro-ops into requests on a req/ack data-SRAM bus.
- Stalls the upstream pipeline while an access is outstanding.
- Checks address alignment and raises address-error exceptions.
- Produces the mem_dreg, mem_dre and mem_device values that memwb_reg registers.

Parameters:
DEV_BASE, 16'hBFAF, address bits [31:16] that mark the MMIO device region.
ADDR_W, 32, SRAM byte-address width.

Ports:
cpu_clk_50M  in  1  core clock
cpu_rst_n  in  1  synchronous active-low reset, sampled on cpu_clk_50M rising edge
mem_memop_i  in  4  memory micro-op (MEMOP_NONE/LB/LBU/LH/LHU/LW/SB/SH/SW)
mem_addr_i  in  32  effective address (ALU result)
mem_wd_i  in  32  ALU result for non-memory ops
mem_din_i  in  32  store data (rt)
mem_wreg_i  in  1  register write enable from EX
flush  in  1  pipeline flush
mem_dreg  out  32  load raw word or ALU result, to memwb_reg
mem_dre  out  5  [3:0] byte-lane select, [4] sign-extend, to memwb_reg
mem_mreg  out  1  1 = writeback source is memory
mem_wreg  out  1  gated register write enable
mem_device  out  1  access targets the DEV_BASE region
stall_req  out  1  hold PC/IF/ID/EX/exmem
exc_adel  out  1  load address error
exc_ades  out  1  store address error
badvaddr  out  32  faulting address
data_sram_req  out  1  request valid
data_sram_we  out  4  byte write strobes, 0 = read
data_sram_addr  out  32  word-aligned address
data_sram_wdata  out  32  lane-replicated store data
data_sram_ack  in  1  request accepted; for reads, rdata is valid in the same cycle
data_sram_rdata  in  32  read data

Behaviour:
- Reset (cpu_rst_n=0 at a clock edge):
  - state=IDLE; data_sram_req=0, we=0, addr=0, wdata=0.
  - Latched rdata=0; flush_pend=0.
  - Combinational outputs follow from IDLE with the current inputs.
  - Reset during REQ drops the request immediately; the SRAM side must tolerate this.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If memop≠NONE, address is aligned and flush=0: stall_req=1; next edge registers addr/we/wdata, req=1, state→REQ.
  - If memop=NONE: pass-through, mem_dreg=mem_wd_i, no stall.
- REQ:
  - req, addr, we and wdata are held stable until ack; stall_req=1.
  - On ack: rdata is latched; state→DONE, or →IDLE if flush_pend (data discarded, flush_pend cleared); req=0 at the next edge.
- DONE:
  - stall_req=0; for loads mem_dreg=latched rdata.
  - memwb_reg captures and the pipeline advances on this edge; state→IDLE.
- Latency: with zero-wait ack, a memop occupies MEM for 3 cycles (IDLE, REQ, DONE). Each extra wait cycle adds 1.
- Alignment:
  - LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
  - On violation: no request, no stall; exc_adel (loads) or exc_ades (stores)=1.
  - badvaddr=mem_addr_i; mem_wreg=0.
  - Otherwise both exc outputs are 0 and badvaddr=0.
- Byte lanes (little-endian):
  - SB: we=1<<addr[1:0].
  - SH: we=4'b0011 or 4'b1100.
  - SW: we=4'b1111.
  - Store data is replicated across lanes.
  - mem_dre[3:0] uses the same lane map for loads; mem_dre[4]=1 for LB/LH; mem_dre=0 for non-loads.
- mem_mreg=1 for loads only.
- mem_device = (mem_addr_i[31:16]==DEV_BASE) when memop≠NONE, else 0.
- Flush:
  - In IDLE: suppresses issue.
  - In REQ: the bus request cannot be withdrawn. flush_pend is set, stall_req stays 1 until ack, and the result is discarded.
  - In DONE: no effect, since memwb_reg flushes its own copy.

Decomposition:
- defines.v holds: MEMOP_* encodings, DRESEL_BUS [4:0], exception codes ADEL=4 and ADES=5, FSM state encodings.
- One combinational sub-module, mem_lane_gen: memop + addr[1:0] + din → we, wdata, dre, misalign.

Test Plan:
1. LW at 0x0000_1004, ack on first REQ cycle, rdata=0xDEADBEEF -> stall_req high 2 cycles; in DONE mem_dreg=0xDEADBEEF, mem_dre=5'b01111, mem_mreg=1.
2. SB din=0x000000AB at 0x0000_2002 -> we=4'b0100, wdata=0xABABABAB, addr=0x0000_2000; req held through 3 wait cycles until ack.
3. LH at 0x0000_3001 -> exc_adel=1, badvaddr=0x0000_3001, data_sram_req never asserted, stall_req=0, mem_wreg=0.
4. LW with flush pulsed in the first REQ cycle, ack 2 cycles later -> req held until ack, state returns to IDLE without DONE, stall_req drops after ack.
5. SW at 0xBFAF_8000 -> mem_device=1, we=4'b1111; reset asserted during REQ -> req=0 the next cycle, state IDLE.
6. Back-to-back LB (addr low bits 3) and ADDU -> LB gives mem_dre=5'b11000; ADDU passes mem_wd_i through with no stall in the cycle after DONE.
